// File: rtl/demux32_deser.sv
// demux32_deser: collects 32 serial N-bit words into 32 registered frame slots
// (out00..out31) and presents the completed frame with a valid/ready handshake.
// While a frame is held the block stops taking input; once the frame is released
// the next word goes into slot 0 again.
// Optional feature: define DEMUX32_FLUSH_EN to add a synchronous 'flush' input.
// Flush aborts the current frame. It leaves the slot contents as they are.
module demux32_deser #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic [4:0]   index,
    output logic [N-1:0] out00,
    output logic [N-1:0] out01,
    output logic [N-1:0] out02,
    output logic [N-1:0] out03,
    output logic [N-1:0] out04,
    output logic [N-1:0] out05,
    output logic [N-1:0] out06,
    output logic [N-1:0] out07,
    output logic [N-1:0] out08,
    output logic [N-1:0] out09,
    output logic [N-1:0] out10,
    output logic [N-1:0] out11,
    output logic [N-1:0] out12,
    output logic [N-1:0] out13,
    output logic [N-1:0] out14,
    output logic [N-1:0] out15,
    output logic [N-1:0] out16,
    output logic [N-1:0] out17,
    output logic [N-1:0] out18,
    output logic [N-1:0] out19,
    output logic [N-1:0] out20,
    output logic [N-1:0] out21,
    output logic [N-1:0] out22,
    output logic [N-1:0] out23,
    output logic [N-1:0] out24,
    output logic [N-1:0] out25,
    output logic [N-1:0] out26,
    output logic [N-1:0] out27,
    output logic [N-1:0] out28,
    output logic [N-1:0] out29,
    output logic [N-1:0] out30,
    output logic [N-1:0] out31,
    output logic         out_valid,
    input  logic         out_ready
`ifdef DEMUX32_FLUSH_EN
    ,
    input  logic         flush
`endif
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t       state_r;
    state_t       state_n_s;
    logic [4:0]   index_r;
    logic [4:0]   index_n_s;
    logic [N-1:0] slot_r [32];
    logic         flush_s;
    logic         transfer_s;
    logic         release_s;

    // Qualify the handshakes; a flush cancels both a word capture and a frame release
    always_comb begin
        flush_s    = 1'b0;
`ifdef DEMUX32_FLUSH_EN
        flush_s    = flush;
`endif
        transfer_s = in_valid && (state_r == ST_FILL) && !flush_s;
        release_s  = out_ready && (state_r == ST_FULL) && !flush_s;
    end

    // Next-state and next-index logic for the fill/full controller
    always_comb begin
        state_n_s = state_r;
        index_n_s = index_r;
        if (flush_s) begin
            state_n_s = ST_FILL;
            index_n_s = 5'd0;
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (transfer_s && (index_r == 5'd31)) begin
                        state_n_s = ST_FULL;
                        index_n_s = 5'd0;
                    end else if (transfer_s) begin
                        index_n_s = index_r + 5'd1;
                    end else begin
                        index_n_s = index_r;
                    end
                end
                ST_FULL: begin
                    if (release_s) begin
                        state_n_s = ST_FILL;
                        index_n_s = 5'd0;
                    end else begin
                        state_n_s = ST_FULL;
                    end
                end
                default: begin
                    state_n_s = ST_FILL;
                    index_n_s = 5'd0;
                end
            endcase
        end
    end

    // State and write-pointer registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_FILL;
            index_r <= 5'd0;
        end else begin
            state_r <= state_n_s;
            index_r <= index_n_s;
        end
    end

    // Frame slot storage: only the addressed slot loads on a transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                slot_r[k] <= '0;
            end
        end else if (transfer_s) begin
            slot_r[index_r] <= in_data;
        end
    end

    assign in_ready  = (state_r == ST_FILL);
    assign out_valid = (state_r == ST_FULL);
    assign index     = index_r;

    assign out00 = slot_r[0];
    assign out01 = slot_r[1];
    assign out02 = slot_r[2];
    assign out03 = slot_r[3];
    assign out04 = slot_r[4];
    assign out05 = slot_r[5];
    assign out06 = slot_r[6];
    assign out07 = slot_r[7];
    assign out08 = slot_r[8];
    assign out09 = slot_r[9];
    assign out10 = slot_r[10];
    assign out11 = slot_r[11];
    assign out12 = slot_r[12];
    assign out13 = slot_r[13];
    assign out14 = slot_r[14];
    assign out15 = slot_r[15];
    assign out16 = slot_r[16];
    assign out17 = slot_r[17];
    assign out18 = slot_r[18];
    assign out19 = slot_r[19];
    assign out20 = slot_r[20];
    assign out21 = slot_r[21];
    assign out22 = slot_r[22];
    assign out23 = slot_r[23];
    assign out24 = slot_r[24];
    assign out25 = slot_r[25];
    assign out26 = slot_r[26];
    assign out27 = slot_r[27];
    assign out28 = slot_r[28];
    assign out29 = slot_r[29];
    assign out30 = slot_r[30];
    assign out31 = slot_r[31];

endmodule

// File: doc/demux32_deser.md
DEMUX32_DESER -- requirements
Module: demux32_deser

Interface
REQ-001 SHALL have parameter N, default 1, giving the width in bits of each data word and each output slot.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data holds a word offered for capture.
REQ-005 SHALL have port in_data, input, N bits: the serial data word.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port index, output, 5 bits: the slot number the next accepted word is written to.
REQ-008 SHALL have ports out00..out31, output, N bits each: the 32 registered frame slots.
REQ-009 SHALL have port out_valid, output, 1 bit: out00..out31 hold a complete frame.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the frame this cycle.
REQ-011 SHALL have port flush, input, 1 bit, only when DEMUX32_FLUSH_EN is defined: abort the current frame.

Function
REQ-012 SHALL have two states:
- FILL: in_ready=1, out_valid=0.
- FULL: in_ready=0, out_valid=1.
REQ-013 SHALL accept a word only on a cycle with in_valid && in_ready (transfer), and on a transfer:
- write in_data into slot index, i.e. out00 for index 0 through out31 for index 31, at the next edge;
- leave all other slots unchanged.
REQ-014 SHALL increment index by 1 on each transfer in FILL while index < 31.
REQ-015 SHALL, on a transfer with index == 31, write out31, set index to 0 and enter FULL at the same edge, so out_valid rises the cycle after the 32nd word.
REQ-016 SHALL hold index and all slots unchanged on any FILL cycle without a transfer; gaps in in_valid are legal.
REQ-017 SHALL, in FULL, hold out00..out31 stable and ignore in_valid until release.
REQ-018 SHALL release the frame when out_valid && out_ready, and on release:
- enter FILL at the next edge with index 0;
- not clear the slots;
- accept no word in the release cycle itself.
REQ-019 SHALL ignore out_ready in FILL.
REQ-020 SHALL produce a frame in which slot k holds the k-th word accepted since the last release or reset (0-based).
REQ-021 SHALL give each slot an exact N-bit copy of its word; no width conversion.

Reset
REQ-022 SHALL, while rst is low, asynchronously force:
- state FILL, index 0, out00..out31 all 0;
- out_valid 0, in_ready 1 once rst deasserts.
REQ-023 SHALL, on reset mid-frame, discard the partial frame with no output effect beyond REQ-022.
REQ-024 SHALL take its first transfer on the first rising edge with rst high and in_valid high.

Configuration
REQ-025 SHALL compile the flush feature in only when macro DEMUX32_FLUSH_EN is defined.
REQ-026 SHALL, with DEMUX32_FLUSH_EN defined, synchronously force state FILL and index 0 on an edge with flush high:
- applies in any state; flush wins over a simultaneous transfer, including the 32nd word;
- flush wins over a simultaneous release;
- slot contents are not cleared.
REQ-027 SHALL, with DEMUX32_FLUSH_EN undefined, have no flush port and no flush logic; behaviour is exactly REQ-012..REQ-021.

Verification
REQ-028 SHALL cover a basic frame: after reset, 32 consecutive transfers of words 0..31 (N=8) -> out_valid=1 the cycle after word 31, outK==K for all K, in_ready=0.
REQ-029 SHALL cover backpressure: FULL with out_ready=0 for 10 cycles while in_valid=1 with data 8'hAA -> slots unchanged, index 0; then out_ready=1 for one cycle -> FILL next cycle, in_ready=1.
REQ-030 SHALL cover gaps: 32 words delivered with in_valid low on every other cycle -> same frame as REQ-028, out_valid after 63 cycles.
REQ-031 SHALL cover async reset: rst low mid-cycle after 17 transfers -> outputs zero immediately without a clock edge; next frame starts at index 0.
REQ-032 SHALL cover flush (macro defined): flush=1 together with the 32nd transfer -> out_valid stays 0, index 0, and the next 32 words form a full frame.
REQ-033 SHALL cover back-to-back frames: two consecutive frames with out_ready held 1 -> exactly one idle input cycle (the release cycle) between frames, second frame correct.
